instruction_fetch: RTL and testbench

Fetch/decode sequencer directly downstream of the 4-bit program counter. Reads the PC value, fetches an 8-bit instruction from a 16-word internal program memory, resolves control-flow opcodes (NOP, JMP, HLT) locally, and hands every other instruction to the execute stage over a valid/ready handshake. It drives the PC's increment, load and output-enable controls.

---
 rtl/instruction_fetch_pkg.sv | 31 +++
 rtl/instruction_fetch_prog_mem.sv | 32 +++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the fetch/decode sequencer: field widths, the
// control-flow opcodes resolved locally, the FSM state encoding and a small
// helper that extracts the opcode field from an instruction word.
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int ADDR_W = 4;  // program address width, equal to the PC width
  localparam int DATA_W = 8;  // instruction width: [7:4] opcode, [3:0] operand
  localparam int OPC_W  = 4;  // opcode field width

  localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'hE;
  localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

  // FSM state encoding, kept as plain constants for compatibility with
  // existing tooling that inspects the state register numerically.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ADDR   = 3'd1;
  localparam state_t ST_FETCH  = 3'd2;
  localparam state_t ST_DECODE = 3'd3;
  localparam state_t ST_ISSUE  = 3'd4;
  localparam state_t ST_HALT   = 3'd5;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/instruction_fetch_prog_mem.sv
// ----------------------------------------------------------------------------
// instruction_fetch_prog_mem
// 16-word program memory: synchronous write, combinational read.
//   CLK    in  system clock
//   we     in  write strobe (already qualified by the sequencer state)
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address (the sequencer's memory address register)
//   rdata  out read data, combinational from raddr
// ----------------------------------------------------------------------------
module instruction_fetch_prog_mem
  import instruction_fetch_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset on purpose: the program must survive RESET,
  // and a reset loop over a memory would also block RAM inference.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch/decode sequencer sitting after the 4-bit program counter. It reads the
// PC, fetches the instruction from internal program memory, resolves NOP/JMP/
// HLT itself and issues every other instruction to execute over valid/ready.
//   CLK, RESET            clock; synchronous active-high reset
//   start                 one-cycle pulse that leaves IDLE
//   pc_value              PC count, sampled while pc_oe is high
//   pc_oe, pc_en, pc_we   PC output enable / increment / load strobes
//   pc_load               PC load value (zero unless pc_we is high)
//   prog_we/addr/data     program-memory write port, honoured in IDLE/HALT
//   ir, instr_valid       instruction register and its valid flag
//   instr_ready           execute accepts ir
//   busy, halted          status: running / stopped in HALT
// ----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              pc_oe,
  output logic              pc_en,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_load,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] ir,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              halted
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mem_rdata;
  logic [OPC_W-1:0]  opc;
  logic              mem_we;
  logic              in_decode;

  assign opc = opcode_of(ir);

  // Writes are only safe while nothing is being fetched.
  assign mem_we = prog_we && ((state == ST_IDLE) || (state == ST_HALT));

  instruction_fetch_prog_mem u_prog_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (mar),
    .rdata (mem_rdata)
  );

  // NOTE: next_state is defaulted before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ADDR;
      ST_ADDR:   state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (opc == OPC_HLT)                          state_nxt = ST_HALT;
        else if ((opc == OPC_NOP) || (opc == OPC_JMP)) state_nxt = ST_ADDR;
        else                                         state_nxt = ST_ISSUE;
      end
      ST_ISSUE:  if (instr_ready) state_nxt = ST_ADDR;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      mar   <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ADDR)  mar <= pc_value;
      if (state == ST_FETCH) ir  <= mem_rdata;
    end
  end

  // Moore decode: strobes depend only on state and ir, so they are stable
  // for the whole cycle. HLT takes neither PC strobe; JMP loads instead of
  // incrementing, which keeps pc_en and pc_we mutually exclusive.
  assign in_decode   = (state == ST_DECODE);
  assign pc_oe       = (state == ST_ADDR);
  assign pc_we       = in_decode && (opc == OPC_JMP);
  assign pc_en       = in_decode && (opc != OPC_JMP) && (opc != OPC_HLT);
  assign pc_load     = pc_we ? ir[ADDR_W-1:0] : '0;
  assign instr_valid = (state == ST_ISSUE);
  assign busy        = (state != ST_IDLE) && (state != ST_HALT);
  assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch. An external 4-bit PC is modelled
// here and driven by pc_en/pc_we. Expected behaviour comes from a program-level
// walker: it steps through the program word by word, charging 3 cycles per
// NOP/JMP, 3 cycles plus the wait for ready per issued instruction, and
// stopping on HLT.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int MAXC = 128;

  logic              CLK = 1'b0;
  logic              RESET, start, prog_we, instr_ready;
  logic [ADDR_W-1:0] prog_addr, pc_value, pc_load;
  logic [DATA_W-1:0] prog_data, ir;
  logic              pc_oe, pc_en, pc_we, instr_valid, busy, halted;

  instruction_fetch dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .pc_value    (pc_value),
    .pc_oe       (pc_oe),
    .pc_en       (pc_en),
    .pc_we       (pc_we),
    .pc_load     (pc_load),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .ir          (ir),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  // External program counter driven by the DUT's strobes.
  logic [ADDR_W-1:0] pc;
  always @(posedge CLK) begin
    if (RESET)      pc <= '0;
    else if (pc_we) pc <= pc_load;
    else if (pc_en) pc <= pc + 4'd1;
  end
  assign pc_value = pc;

  int vectors    = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model_mem [16];
  bit                ready_pat [MAXC+1];
  int                inj_we_cyc = -1, inj_start_cyc = -1;
  logic [ADDR_W-1:0] inj_addr = '0;
  logic [DATA_W-1:0] inj_data = '0;

  // Observed results of one run
  logic [DATA_W-1:0] got_ir [$];
  int                got_cyc [$];
  logic [ADDR_W-1:0] got_load [$];
  int                got_en, got_we, got_oe, got_halt, flag_err;
  // Expected results of one run
  logic [DATA_W-1:0] exp_ir [$];
  int                exp_cyc [$];
  logic [ADDR_W-1:0] exp_load [$];
  int                exp_en, exp_we, exp_oe, exp_halt;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; start = 1'b0; prog_we = 1'b0; instr_ready = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  // Only called while the DUT sits in IDLE or HALT.
  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    prog_addr = a; prog_data = d; prog_we = 1'b1;
    tick();
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic ready_all(input bit v);
    for (int i = 0; i <= MAXC; i++) ready_pat[i] = v;
  endtask

  // Program-level reference: cycle 1 is the first ADDR cycle after start.
  task automatic model_run(input int maxc);
    logic [3:0] mpc;
    logic [7:0] w;
    int t, c;
    bit done;
    exp_ir.delete(); exp_cyc.delete(); exp_load.delete();
    exp_en = 0; exp_we = 0; exp_oe = 0; exp_halt = -1;
    mpc = 4'd0; t = 1; done = 1'b0;
    while (!done && t <= maxc) begin
      exp_oe++;
      w = model_mem[mpc];
      case (w[7:4])
        OPC_NOP: begin
          if (t + 2 <= maxc) exp_en++;
          mpc = mpc + 4'd1; t += 3;
        end
        OPC_JMP: begin
          if (t + 2 <= maxc) begin exp_we++; exp_load.push_back(w[3:0]); end
          mpc = w[3:0]; t += 3;
        end
        OPC_HLT: begin
          if (t + 3 <= maxc) exp_halt = t + 3;
          done = 1'b1;
        end
        default: begin
          if (t + 2 <= maxc) exp_en++;
          c = t + 3;
          while (c <= maxc && !ready_pat[c]) c++;
          if (c <= maxc) begin
            exp_ir.push_back(w); exp_cyc.push_back(c);
            mpc = mpc + 4'd1; t = c + 1;
          end else done = 1'b1;
        end
      endcase
    end
  endtask

  // Pulse start from IDLE and observe cycles 1..maxc.
  task automatic run_dut(input int maxc);
    bit waiting;
    logic [7:0] held;
    got_ir.delete(); got_cyc.delete(); got_load.delete();
    got_en = 0; got_we = 0; got_oe = 0; got_halt = -1; flag_err = 0;
    waiting = 1'b0; held = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= maxc; cyc++) begin
      if (cyc > 1) tick();
      instr_ready = ready_pat[cyc];
      prog_we     = (cyc == inj_we_cyc);
      prog_addr   = inj_addr;
      prog_data   = inj_data;
      start       = (cyc == inj_start_cyc);
      if (pc_en && pc_we) flag_err++;
      if (waiting && (!instr_valid || ir !== held || pc_en || pc_we || pc_oe)) flag_err++;
      if (halted && got_halt < 0) got_halt = cyc;
      if (busy === halted) flag_err++;
      if (pc_oe) got_oe++;
      if (pc_en) got_en++;
      if (pc_we) begin got_we++; got_load.push_back(pc_load); end
      if (instr_valid && instr_ready) begin got_ir.push_back(ir); got_cyc.push_back(cyc); end
      waiting = instr_valid && !instr_ready;
      held = ir;
    end
    prog_we = 1'b0; start = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; prog_we = 1'b0; instr_ready = 1'b0;
    prog_addr = '0; prog_data = '0;
    tick(); tick();
    RESET = 1'b0;
    vectors++;
    if ({pc_oe, pc_en, pc_we, pc_load, instr_valid, busy, halted, ir} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_state: outputs %b required all zero",
               {pc_oe, pc_en, pc_we, pc_load, instr_valid, busy, halted, ir});
    end
    write_word(4'd0, 8'h3C);
    write_word(4'd1, 8'hF0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (instr_valid !== 1'b1 || ir !== 8'h3C) begin
      miscompares++;
      $display("FAIL reset_pre_issue: valid=%b ir=%h required valid=1 ir=3c", instr_valid, ir);
    end
    RESET = 1'b1; tick(); RESET = 1'b0;
    vectors++;
    if ({pc_oe, pc_en, pc_we, pc_load, instr_valid, busy, halted, ir} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_mid_issue: outputs %b required all zero",
               {pc_oe, pc_en, pc_we, pc_load, instr_valid, busy, halted, ir});
    end
    ready_all(1'b1);
    model_run(12);
    run_dut(12);
    vectors++;
    if (got_ir.size() != 1 || got_ir[0] !== exp_ir[0] || got_cyc[0] != exp_cyc[0]) begin
      miscompares++;
      $display("FAIL reset_mem_retained: issued %0d words first=%h, required %h at cycle %0d",
               got_ir.size(), (got_ir.size() > 0) ? got_ir[0] : 8'hxx, exp_ir[0], exp_cyc[0]);
    end
  endtask

  task automatic test_linear();
    do_reset();
    write_word(4'd0, 8'h31); write_word(4'd1, 8'h52); write_word(4'd2, 8'hF0);
    ready_all(1'b1);
    model_run(16);
    run_dut(16);
    vectors++;
    if (got_ir.size() != exp_ir.size()) begin
      miscompares++;
      $display("FAIL linear_count: issued %0d required %0d", got_ir.size(), exp_ir.size());
    end else begin
      for (int i = 0; i < exp_ir.size(); i++) begin
        vectors++;
        if (got_ir[i] !== exp_ir[i] || got_cyc[i] != exp_cyc[i]) begin
          miscompares++;
          $display("FAIL linear_issue[%0d]: ir=%h cycle %0d required ir=%h cycle %0d",
                   i, got_ir[i], got_cyc[i], exp_ir[i], exp_cyc[i]);
        end
      end
    end
    vectors++;
    if (got_en != exp_en || got_we != exp_we || got_oe != exp_oe) begin
      miscompares++;
      $display("FAIL linear_strobes: en=%0d we=%0d oe=%0d required en=%0d we=%0d oe=%0d",
               got_en, got_we, got_oe, exp_en, exp_we, exp_oe);
    end
    vectors++;
    if (got_halt != exp_halt || flag_err != 0) begin
      miscompares++;
      $display("FAIL linear_halt: halt cycle %0d errors %0d required halt cycle %0d errors 0",
               got_halt, flag_err, exp_halt);
    end
  endtask

  task automatic test_jmp();
    do_reset();
    write_word(4'd0, 8'hE5); write_word(4'd5, 8'h47); write_word(4'd6, 8'hF0);
    ready_all(1'b1);
    model_run(20);
    run_dut(20);
    vectors++;
    if (got_we != exp_we || got_load.size() != 1 || got_load[0] !== exp_load[0]) begin
      miscompares++;
      $display("FAIL jmp_load: pc_we pulses %0d load=%h required %0d pulses load=%h",
               got_we, (got_load.size() > 0) ? got_load[0] : 4'hx, exp_we, exp_load[0]);
    end
    vectors++;
    if (got_ir.size() != 1 || got_ir[0] !== exp_ir[0] || got_cyc[0] != exp_cyc[0]) begin
      miscompares++;
      $display("FAIL jmp_target: issued %0d words first=%h required %h at cycle %0d",
               got_ir.size(), (got_ir.size() > 0) ? got_ir[0] : 8'hxx, exp_ir[0], exp_cyc[0]);
    end
    vectors++;
    if (got_en != exp_en || got_halt != exp_halt || flag_err != 0) begin
      miscompares++;
      $display("FAIL jmp_flow: en=%0d halt=%0d errors=%0d required en=%0d halt=%0d errors=0",
               got_en, got_halt, flag_err, exp_en, exp_halt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_word(4'd0, 8'h31); write_word(4'd1, 8'hF0);
    ready_all(1'b1);
    for (int c = 4; c <= 9; c++) ready_pat[c] = 1'b0;
    model_run(20);
    run_dut(20);
    vectors++;
    if (got_ir.size() != 1 || got_ir[0] !== exp_ir[0] || got_cyc[0] != exp_cyc[0]) begin
      miscompares++;
      $display("FAIL backpressure_transfer: issued %0d words cycle %0d required %h at cycle %0d",
               got_ir.size(), (got_cyc.size() > 0) ? got_cyc[0] : -1, exp_ir[0], exp_cyc[0]);
    end
    vectors++;
    if (flag_err != 0 || got_en != exp_en || got_oe != exp_oe || got_halt != exp_halt) begin
      miscompares++;
      $display("FAIL backpressure_hold: errors=%0d en=%0d oe=%0d halt=%0d required 0/%0d/%0d/%0d",
               flag_err, got_en, got_oe, got_halt, exp_en, exp_oe, exp_halt);
    end
  endtask

  task automatic test_nop_skip();
    do_reset();
    write_word(4'd0, 8'h00); write_word(4'd1, 8'h21); write_word(4'd2, 8'hF0);
    ready_all(1'b1);
    model_run(20);
    run_dut(20);
    vectors++;
    if (got_ir.size() != 1 || got_ir[0] !== exp_ir[0] || got_cyc[0] != exp_cyc[0]) begin
      miscompares++;
      $display("FAIL nop_skip: issued %0d words first cycle %0d required %h at cycle %0d",
               got_ir.size(), (got_cyc.size() > 0) ? got_cyc[0] : -1, exp_ir[0], exp_cyc[0]);
    end
    vectors++;
    if (got_en != exp_en || got_we != 0 || flag_err != 0) begin
      miscompares++;
      $display("FAIL nop_strobes: en=%0d we=%0d errors=%0d required en=%0d we=0 errors=0",
               got_en, got_we, flag_err, exp_en);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    write_word(4'd0, 8'h31); write_word(4'd1, 8'h52); write_word(4'd2, 8'hF0);
    ready_all(1'b1);
    inj_we_cyc = 2; inj_addr = 4'd1; inj_data = 8'h99;  // write during FETCH
    inj_start_cyc = 4;                                  // start during ISSUE
    model_run(16);
    run_dut(16);
    inj_we_cyc = -1; inj_start_cyc = -1;
    vectors++;
    if (got_ir.size() != 2 || got_ir[1] !== exp_ir[1] || got_cyc[1] != exp_cyc[1]) begin
      miscompares++;
      $display("FAIL illegal_write_start: issued %0d words second=%h required %h at cycle %0d",
               got_ir.size(), (got_ir.size() > 1) ? got_ir[1] : 8'hxx, exp_ir[1], exp_cyc[1]);
    end
    vectors++;
    if (got_halt != exp_halt || flag_err != 0) begin
      miscompares++;
      $display("FAIL illegal_halt: halt=%0d errors=%0d required halt=%0d errors=0",
               got_halt, flag_err, exp_halt);
    end
    // Now in HALT: writes land, start is ignored.
    write_word(4'd3, 8'h6A);
    write_word(4'd4, 8'hF0);
    start = 1'b1; tick(); start = 1'b0; tick();
    vectors++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_sticky: halted=%b busy=%b pc_oe=%b required 1/0/0", halted, busy, pc_oe);
    end
    do_reset();
    write_word(4'd0, 8'hE3);
    model_run(20);
    run_dut(20);
    vectors++;
    if (got_ir.size() != 1 || got_ir[0] !== exp_ir[0] || got_cyc[0] != exp_cyc[0]) begin
      miscompares++;
      $display("FAIL halt_write_visible: issued %0d words first=%h required %h at cycle %0d",
               got_ir.size(), (got_ir.size() > 0) ? got_ir[0] : 8'hxx, exp_ir[0], exp_cyc[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int iter = 0; iter < 8; iter++) begin
      do_reset();
      for (int a = 0; a < 16; a++) begin
        case ($urandom_range(0, 7))
          0:       op = OPC_NOP;
          1:       op = OPC_JMP;
          2:       op = (a > 8) ? OPC_HLT : 4'h3;
          default: op = 4'($urandom_range(1, 13));
        endcase
        write_word(4'(a), {op, 4'($urandom_range(0, 15))});
      end
      for (int c = 0; c <= MAXC; c++) ready_pat[c] = ($urandom_range(0, 9) < 6);
      model_run(80);
      run_dut(80);
      vectors++;
      if (got_ir.size() != exp_ir.size()) begin
        miscompares++;
        $display("FAIL random%0d_count: issued %0d required %0d", iter, got_ir.size(), exp_ir.size());
      end else begin
        for (int i = 0; i < exp_ir.size(); i++) begin
          vectors++;
          if (got_ir[i] !== exp_ir[i] || got_cyc[i] != exp_cyc[i]) begin
            miscompares++;
            $display("FAIL random%0d_issue[%0d]: ir=%h cycle %0d required ir=%h cycle %0d",
                     iter, i, got_ir[i], got_cyc[i], exp_ir[i], exp_cyc[i]);
          end
        end
      end
      vectors++;
      if (got_en != exp_en || got_we != exp_we || got_oe != exp_oe || got_halt != exp_halt || flag_err != 0) begin
        miscompares++;
        $display("FAIL random%0d_flow: en=%0d we=%0d oe=%0d halt=%0d err=%0d required %0d/%0d/%0d/%0d/0",
                 iter, got_en, got_we, got_oe, got_halt, flag_err, exp_en, exp_we, exp_oe, exp_halt);
      end
      vectors++;
      if (got_load != exp_load) begin
        miscompares++;
        $display("FAIL random%0d_jmp_loads: %0d loads observed, %0d required or values differ",
                 iter, got_load.size(), exp_load.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_jmp();
    test_backpressure();
    test_nop_skip();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
